// File: rtl/ppu_pkg.sv
// ppu_pkg: register selects, command record and engine states shared by the VRAM port.
package ppu_pkg;
  localparam logic [2:0] PPUCTRL   = 3'd0;
  localparam logic [2:0] PPUMASK   = 3'd1;
  localparam logic [2:0] PPUSTATUS = 3'd2;
  localparam logic [2:0] OAMADDR   = 3'd3;
  localparam logic [2:0] OAMDATA   = 3'd4;
  localparam logic [2:0] PPUSCROLL = 3'd5;
  localparam logic [2:0] PPUADDR   = 3'd6;
  localparam logic [2:0] PPUDATA   = 3'd7;
  localparam int PPU_ADDR_W = 14;
  localparam int PPU_DATA_W = 8;
  typedef struct packed {
    logic                  we;
    logic [PPU_ADDR_W-1:0] addr;
    logic [PPU_DATA_W-1:0] data;
  } ppu_cmd_t;
  typedef enum logic {IDLE, REQ} eng_state_e;
endpackage

// File: rtl/ppu_cmd_fifo.sv
// ppu_cmd_fifo: in-order command FIFO; a push into a full FIFO lands only if the head pops that cycle.
module ppu_cmd_fifo #(
  parameter int W     = 23,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  logic         do_push, do_pop;
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/ppu_vram_port.sv
// ppu_vram_port: CPU PPUADDR/PPUDATA front end queuing VRAM accesses to the memory arbiter.
// Define VRAM_MIRROR_EN to fold issued addresses 0x3000-0x3EFF onto 0x2000-0x2EFF.
module ppu_vram_port
  import ppu_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              ncs_in,
  input  logic              r_nw_in,
  input  logic [2:0]        sel_in,
  input  logic [DATA_W-1:0] cpu_d_in,
  output logic [DATA_W-1:0] cpu_d_out,
  input  logic              addr_incr_in,
  output logic              mem_req_out,
  output logic              mem_we_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_wdata_out,
  input  logic              mem_ack_in,
  input  logic [DATA_W-1:0] mem_rdata_in,
  output logic [ADDR_W-1:0] vaddr_out,
  output logic              busy_out,
  output logic              ovf_out
);
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;
  cmd_t              push_cmd, head;
  eng_state_e        state_q, state_d;
  logic              ncs_q, byte_sel_q, byte_sel_d, ovf_q, ovf_d, we_q, we_d;
  logic              access, addr_wr, stat_rd, push, pop, ack, full, empty;
  logic [5:0]        t_hi_q, t_hi_d;
  logic [ADDR_W-1:0] v_q, v_d, addr_q, addr_d, issue_addr;
  logic [DATA_W-1:0] rd_buf_q, rd_buf_d, dout_q, dout_d, wdata_q, wdata_d;
  ppu_cmd_fifo #(.W($bits(cmd_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_i  (rst_in),
    .push_i (push),
    .data_i (push_cmd),
    .pop_i  (pop),
    .data_o (head),
    .full_o (full),
    .empty_o(empty)
  );
`ifdef VRAM_MIRROR_EN
  assign issue_addr = (head.addr >= ADDR_W'(14'h3000) && head.addr <= ADDR_W'(14'h3EFF)) ?
                      head.addr & ~(ADDR_W'(1) << 12) : head.addr;
`else
  assign issue_addr = head.addr;
`endif
  always_comb begin
    access     = ncs_q & ~ncs_in;
    addr_wr    = access & ~r_nw_in & (sel_in == PPUADDR);
    stat_rd    = access & r_nw_in & (sel_in == PPUSTATUS);
    push       = access & (sel_in == PPUDATA);
    push_cmd   = '{we: ~r_nw_in, addr: v_q, data: cpu_d_in};
    t_hi_d     = addr_wr & ~byte_sel_q ? cpu_d_in[5:0] : t_hi_q;
    byte_sel_d = addr_wr ? ~byte_sel_q : stat_rd ? 1'b0 : byte_sel_q;
    v_d        = addr_wr & byte_sel_q ? ADDR_W'({t_hi_q, cpu_d_in[7:0]}) :
                 push ? v_q + (addr_incr_in ? ADDR_W'(32) : ADDR_W'(1)) : v_q;
    dout_d     = push & r_nw_in ? rd_buf_q : dout_q;
    ovf_d      = ovf_q | (push & full & ~pop);
  end
  // Issue pops the head straight into the request registers; ack only counts in REQ.
  always_comb begin
    pop      = (state_q == IDLE) & ~empty;
    ack      = (state_q == REQ) & mem_ack_in;
    state_d  = pop ? REQ : ack ? IDLE : state_q;
    we_d     = pop ? head.we : we_q;
    addr_d   = pop ? issue_addr : addr_q;
    wdata_d  = pop ? head.data : wdata_q;
    rd_buf_d = ack & ~we_q ? mem_rdata_in : rd_buf_q;
  end
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      ncs_q      <= 1'b1;
      byte_sel_q <= 1'b0;
      t_hi_q     <= '0;
      v_q        <= '0;
      dout_q     <= '0;
      rd_buf_q   <= '0;
      ovf_q      <= 1'b0;
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      ncs_q      <= ncs_in;
      byte_sel_q <= byte_sel_d;
      t_hi_q     <= t_hi_d;
      v_q        <= v_d;
      dout_q     <= dout_d;
      rd_buf_q   <= rd_buf_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end
  assign mem_req_out   = state_q == REQ;
  assign mem_we_out    = we_q;
  assign mem_addr_out  = addr_q;
  assign mem_wdata_out = wdata_q;
  assign cpu_d_out     = dout_q;
  assign vaddr_out     = v_q;
  assign busy_out      = ~empty | mem_req_out;
  assign ovf_out       = ovf_q;
endmodule

// File: tb/tb_ppu_vram_port.sv
// tb_ppu_vram_port: random CPU accesses against a programmer-level model plus a VRAM arbiter stub.
module tb_ppu_vram_port;
  localparam int FD = 4;
  logic        clk = 1'b0, rst_in = 1'b1, ncs_in = 1'b1, r_nw_in = 1'b1, addr_incr_in = 1'b0;
  logic        mem_ack_in = 1'b0, mem_req_out, mem_we_out, busy_out, ovf_out;
  logic [2:0]  sel_in = '0;
  logic [7:0]  cpu_d_in = '0, mem_rdata_in = '0, cpu_d_out, mem_wdata_out;
  logic [13:0] mem_addr_out, vaddr_out;
  ppu_vram_port #(.ADDR_W(14), .DATA_W(8), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_in(rst_in), .ncs_in(ncs_in), .r_nw_in(r_nw_in), .sel_in(sel_in),
    .cpu_d_in(cpu_d_in), .cpu_d_out(cpu_d_out), .addr_incr_in(addr_incr_in),
    .mem_req_out(mem_req_out), .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out),
    .mem_wdata_out(mem_wdata_out), .mem_ack_in(mem_ack_in), .mem_rdata_in(mem_rdata_in),
    .vaddr_out(vaddr_out), .busy_out(busy_out), .ovf_out(ovf_out)
  );
  always #20 clk = ~clk;
  typedef struct {logic we; logic [13:0] addr; logic [7:0] data;} exp_t;
  exp_t        exp_q[$];
  logic [7:0]  mem_m [16384];
  logic [7:0]  vram [16384];
  int          n_vec = 0, n_err = 0, pend = 0, lat = 0;
  logic        hold_ack = 1'b0, in_req = 1'b0, bs_m = 1'b0;
  logic [13:0] v_m = '0, cur_addr = '0;
  logic [5:0]  t_hi_m = '0;
  logic [7:0]  dout_m = '0, last_rd = '0;
  function automatic logic [13:0] mir(input logic [13:0] a);
`ifdef VRAM_MIRROR_EN
    return (a >= 14'h3000 && a <= 14'h3EFF) ? (a & ~14'h1000) : a;
`else
    return a;
`endif
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Arbiter stub: checks each issued request against the model queue, acks after 0..3 idle cycles.
  initial forever begin
    @(negedge clk);
    mem_ack_in = 1'b0;
    if (hold_ack || rst_in) continue;
    if (mem_req_out && !in_req) begin
      in_req = 1'b1;
      lat = $urandom_range(0, 3);
      cur_addr = mem_addr_out;
      if (exp_q.size() == 0) chk("unexpected_req", 1, 0);
      else begin
        chk("req_we", mem_we_out, exp_q[0].we);
        chk("req_addr", mem_addr_out, exp_q[0].addr);
        if (exp_q[0].we) chk("req_wdata", mem_wdata_out, exp_q[0].data);
      end
    end
    if (in_req) begin
      if (lat == 0) begin
        chk("req_held", {mem_req_out, mem_addr_out}, {1'b1, cur_addr});
        mem_ack_in = 1'b1;
        mem_rdata_in = vram[mem_addr_out];
        if (mem_we_out) vram[mem_addr_out] = mem_wdata_out;
        in_req = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else lat--;
    end else if ($urandom_range(0, 7) == 0) begin
      mem_ack_in = 1'b1;
      mem_rdata_in = 8'($urandom);
    end
  end
  task automatic wait_idle();
    int i = 0;
    while (busy_out && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk("idle", busy_out, 1'b0);
    pend = 0;
  endtask
  task automatic do_acc(input logic [2:0] s, input logic rnw, input logic [7:0] d, input logic incr,
                        input logic drop);
    if (s == 3'd7 && !hold_ack && (rnw || pend >= 4)) wait_idle();
    @(negedge clk);
    ncs_in = 1'b0; sel_in = s; r_nw_in = rnw; cpu_d_in = d; addr_incr_in = incr;
    @(negedge clk);
    ncs_in = 1'b1; r_nw_in = 1'($urandom); sel_in = 3'($urandom); cpu_d_in = 8'($urandom);
    if (s == 3'd6 && !rnw) begin
      if (!bs_m) t_hi_m = d[5:0];
      else v_m = {t_hi_m, d};
      bs_m = ~bs_m;
    end
    if (s == 3'd2 && rnw) bs_m = 1'b0;
    if (s == 3'd7) begin
      if (rnw) dout_m = last_rd;
      if (!drop) begin
        if (!rnw) begin
          mem_m[mir(v_m)] = d;
          exp_q.push_back('{we: 1'b1, addr: mir(v_m), data: d});
        end else begin
          last_rd = mem_m[mir(v_m)];
          exp_q.push_back('{we: 1'b0, addr: mir(v_m), data: 8'h00});
        end
        pend++;
      end
      v_m = v_m + (incr ? 14'd32 : 14'd1);
    end
    chk("vaddr", vaddr_out, v_m);
    chk("cpu_d_out", cpu_d_out, dout_m);
  endtask
  task automatic set_v(input logic [13:0] a);
    do_acc(3'd6, 1'b0, {2'b00, a[13:8]}, 1'b0, 1'b0);
    do_acc(3'd6, 1'b0, a[7:0], 1'b0, 1'b0);
  endtask
  task automatic rand_ops(input int n);
    for (int k = 0; k < n; k++) begin
      int op = $urandom_range(0, 9);
      logic [7:0] d = 8'($urandom);
      logic inc = 1'($urandom);
      case (op)
        0, 1:    do_acc(3'd6, 1'b0, d, inc, 1'b0);
        2:       do_acc(3'd2, 1'b1, d, inc, 1'b0);
        3, 4, 5: do_acc(3'd7, 1'b0, d, inc, 1'b0);
        6, 7:    do_acc(3'd7, 1'b1, d, inc, 1'b0);
        8:       do_acc(3'd6, 1'b1, d, inc, 1'b0);
        default: do_acc(3'($urandom_range(0, 5)), 1'($urandom), d, inc, 1'b0);
      endcase
    end
  endtask
  initial begin
    for (int i = 0; i < 16384; i++) begin
      vram[i] = 8'($urandom);
      mem_m[i] = vram[i];
    end
    repeat (3) @(negedge clk);
    chk("rst_req", {mem_req_out, mem_we_out}, 2'b00);
    chk("rst_addr", mem_addr_out, 14'h0);
    chk("rst_wdata", mem_wdata_out, 8'h0);
    chk("rst_dout", cpu_d_out, 8'h0);
    chk("rst_flags", {vaddr_out, busy_out, ovf_out}, 16'h0);
    rst_in = 1'b0;
    do_acc(3'd6, 1'b0, 8'h21, 1'b0, 1'b0);
    do_acc(3'd6, 1'b0, 8'h08, 1'b0, 1'b0);
    do_acc(3'd7, 1'b0, 8'h5A, 1'b0, 1'b0);
    chk("t1_vaddr", vaddr_out, 14'h2109);
    set_v(14'h2000);
    repeat (3) do_acc(3'd7, 1'b0, 8'($urandom), 1'b1, 1'b0);
    chk("t2_vaddr", vaddr_out, 14'h2060);
    set_v(14'h2400);
    do_acc(3'd7, 1'b0, 8'h11, 1'b0, 1'b0);
    do_acc(3'd7, 1'b0, 8'h22, 1'b0, 1'b0);
    set_v(14'h2400);
    do_acc(3'd7, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("rd0", cpu_d_out, 8'h00);
    do_acc(3'd7, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("rd1", cpu_d_out, 8'h11);
    do_acc(3'd7, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("rd2", cpu_d_out, 8'h22);
    do_acc(3'd6, 1'b0, 8'h3F, 1'b0, 1'b0);
    do_acc(3'd2, 1'b1, 8'h00, 1'b0, 1'b0);
    do_acc(3'd6, 1'b0, 8'h23, 1'b0, 1'b0);
    do_acc(3'd6, 1'b0, 8'hC0, 1'b0, 1'b0);
    chk("toggle_vaddr", vaddr_out, 14'h23C0);
    set_v(14'h3123);
    do_acc(3'd7, 1'b0, 8'h77, 1'b0, 1'b0);
    rand_ops(200);
    wait_idle();
    chk("ovf_clear", ovf_out, 1'b0);
    chk("drained", exp_q.size(), 0);
    hold_ack = 1'b1;
    for (int i = 0; i < FD + 2; i++) do_acc(3'd7, 1'b0, 8'($urandom), 1'($urandom), i == FD + 1);
    chk("ovf_set", ovf_out, 1'b1);
    chk("held_busy", busy_out, 1'b1);
    chk("held_cnt", exp_q.size(), FD + 1);
    hold_ack = 1'b0;
    wait_idle();
    chk("ovf_drained", exp_q.size(), 0);
    chk("ovf_sticky", ovf_out, 1'b1);
    hold_ack = 1'b1;
    do_acc(3'd7, 1'b0, 8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 10 && !mem_req_out; i++) @(negedge clk);
    chk("req_up", mem_req_out, 1'b1);
    #5 rst_in = 1'b1;
    #1 chk("async_drop", mem_req_out, 1'b0);
    exp_q.delete();
    in_req = 1'b0;
    for (int i = 0; i < 16384; i++) mem_m[i] = vram[i];
    v_m = '0; bs_m = 1'b0; dout_m = '0; last_rd = '0; pend = 0;
    @(negedge clk);
    rst_in = 1'b0;
    hold_ack = 1'b0;
    chk("post_rst", {vaddr_out, busy_out, ovf_out, cpu_d_out}, 24'h0);
    rand_ops(40);
    wait_idle();
    chk("final_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ppu_vram_port.md
# ppu_vram_port

Parametrised CPU-to-PPU video-memory access engine. It replaces the ad-hoc $2006/$2007 handling in the PPU register interface with a dedicated block that:
- maintains the VRAM address pointer;
- queues CPU data-port reads and writes in an in-order command FIFO;
- drains that FIFO to the PPU memory arbiter over a req/ack handshake;
- provides the NES-style one-deep buffered read.

It sits between the CPU register bus decode and the PPU memory arbiter.

## Interface
Parameters:
- ADDR_W, 14, VRAM address width (≥ 14).
- DATA_W, 8, data width.
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥ 2.

Ports (clock and reset first):
- clk  in  1  system clock, 25 MHz. Single clock domain.
- rst_in  in  1  asynchronous, active-high reset.
- ncs_in  in  1  register chip select, active low.
- r_nw_in  in  1  CPU read (1) / write (0).
- sel_in  in  3  register select; 6 = PPUADDR, 7 = PPUDATA, 2 = PPUSTATUS.
- cpu_d_in  in  DATA_W  CPU write data.
- cpu_d_out  out  DATA_W  PPUDATA read data.
- addr_incr_in  in  1  pointer step: 0 = +1, 1 = +32. Supplied by the PPUCTRL owner.
- mem_req_out  out  1  memory request.
- mem_we_out  out  1  1 = write, 0 = read.
- mem_addr_out  out  ADDR_W  memory address.
- mem_wdata_out  out  DATA_W  write data.
- mem_ack_in  in  1  one-cycle acknowledge.
- mem_rdata_in  in  DATA_W  read data, valid in the ack cycle.
- vaddr_out  out  ADDR_W  current VRAM pointer.
- busy_out  out  1  FIFO non-empty or a request is outstanding.
- ovf_out  out  1  sticky flag: a command was dropped because the FIFO was full.

## Operation
Access detection:
- An access is the cycle where q_ncs (registered ncs_in, resets to 1) is 1 and ncs_in is 0.
- Exactly one action is taken per CPU access.

PPUADDR write, selected by byte_sel:
- byte_sel = 0: latch t_hi ← cpu_d_in[5:0]; byte_sel ← 1.
- byte_sel = 1: v ← {zero-extend, t_hi, cpu_d_in}; byte_sel ← 0.

PPUSTATUS read:
- byte_sel ← 0. No other effect in this block.

PPUDATA write:
- Push {we = 1, addr = v, data = cpu_d_in} into the FIFO.
- v ← v + (addr_incr_in ? 32 : 1), modulo 2^ADDR_W.

PPUDATA read:
- cpu_d_out ← rd_buf.
- Push {we = 0, addr = v}.
- v increments as for a write.

FIFO behaviour:
- Commands execute strictly in push order. rd_buf is loaded only when a read command completes.
- Push while full and no pop in the same cycle: the command is dropped, ovf_out is set, and v still increments.
- Push and pop in the same cycle while full: the push is accepted.
- ovf_out clears only on reset.

Engine state machine:
- IDLE → REQ when the FIFO is non-empty. The head entry is popped into the output registers and mem_req_out is set to 1.
- REQ: mem_req_out, mem_we_out, mem_addr_out and mem_wdata_out are held stable until mem_ack_in = 1.
- On ack:
  - if the command was a read, rd_buf ← mem_rdata_in;
  - mem_req_out is cleared;
  - the state returns to IDLE.
- A new request is issued no earlier than the cycle after an ack.
- mem_ack_in is ignored while in IDLE.

Other accesses:
- Accesses to other selects are ignored.
- cpu_d_out holds its value except on a PPUDATA read.

## Timing
Reset values:
- mem_req_out = 0, mem_we_out = 0, mem_addr_out = 0, mem_wdata_out = 0.
- cpu_d_out = 0, vaddr_out = 0, busy_out = 0, ovf_out = 0.
- rd_buf = 0, byte_sel = 0, FIFO empty, state IDLE.

Latencies:
- Access to register update: 1 clk. The update lands on the edge that ends the detect cycle.
- FIFO push to mem_req_out high: minimum 2 clk (push edge, then pop/issue edge).
- Ack to rd_buf valid: same edge.
- A read returns its own data on the next PPUDATA read, provided the engine has completed it.

Reset mid-transaction:
- mem_req_out drops asynchronously.
- The outstanding command is lost.

## Configuration
VRAM_MIRROR_EN:
- Defined: an issued address in 0x3000–0x3EFF is mapped to 0x2000–0x2EFF by clearing bit 12 on mem_addr_out. vaddr_out is unaffected.
- Undefined: mem_addr_out equals the queued address.

## Structure
- Package ppu_pkg holds:
  - select constants PPUCTRL … PPUDATA (0–7);
  - the ppu_cmd_t typedef {we, addr[ADDR_W], data[DATA_W]};
  - engine state encodings IDLE/REQ.
- Sub-module ppu_cmd_fifo: synchronous FIFO with FIFO_DEPTH entries, width 1+ADDR_W+DATA_W, and full/empty flags with simultaneous push/pop support.

## Test plan
- PPUADDR write 0x21, then 0x08; PPUDATA write 0x5A with ack after 3 clk → mem_addr_out = 0x2108, mem_we_out = 1, mem_wdata_out = 0x5A; vaddr_out = 0x2109.
- addr_incr_in = 1, v = 0x2000, three PPUDATA writes → addresses 0x2000, 0x2020, 0x2040 issued in order; vaddr_out = 0x2060.
- Memory at 0x2400 = 0x11 and 0x2401 = 0x22; set v = 0x2400; three PPUDATA reads → cpu_d_out = 0x00, then 0x11, then 0x22.
- mem_ack_in held low; FIFO_DEPTH+2 writes → the first FIFO_DEPTH+1 are held (FIFO_DEPTH queued plus 1 in REQ), the last is dropped, ovf_out = 1; after acks all held writes drain in order.
- PPUADDR first write 0x3F, then a PPUSTATUS read, then PPUADDR writes 0x23 and 0xC0 → v = 0x23C0 (toggle was reset).
- VRAM_MIRROR_EN defined: v = 0x3123, one write → mem_addr_out = 0x2123. Undefined → mem_addr_out = 0x3123.
